// File: rtl/fn_call_arbiter_pkg.sv
// fn_call_arbiter_pkg: default data width and FSM state
// encoding shared by the arbiter and its round-robin picker.
package fn_call_arbiter_pkg;

  localparam int INT_N = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_e;

endpackage

// File: rtl/fn_call_arbiter_rr_pick.sv
// fn_call_arbiter_rr_pick: combinational round-robin picker.
// req/ptr in; grant = first set req at or after ptr, any = req!=0.
module fn_call_arbiter_rr_pick
  import fn_call_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic [OW-1:0] grant,
  output logic          any
);

  int idx;

  // Wrap by compare so non-power-of-two N works.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[OW'(idx)]) begin
        any   = 1'b1;
        grant = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/fn_call_arbiter.sv
// fn_call_arbiter: shares one function instance among N requesters,
// one call at a time, round-robin grant; busy/owner for debug.
module fn_call_arbiter
  import fn_call_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = INT_N
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [N-1:0]                  req_in_valid,
  output logic [N-1:0]                  req_in_ready,
  input  logic [N*W-1:0]                req_in0,
  output logic [N-1:0]                  req_out_valid,
  input  logic [N-1:0]                  req_out_ready,
  output logic [W-1:0]                  req_out0,
  output logic                          fn_in_valid,
  input  logic                          fn_in_ready,
  output logic [W-1:0]                  fn_in0,
  input  logic                          fn_out_valid,
  output logic                          fn_out_ready,
  input  logic [W-1:0]                  fn_out0,
  output logic                          busy,
  output logic [$clog2(N > 1 ? N : 2)-1:0] owner
);

  localparam int OW = $clog2(N > 1 ? N : 2);

  state_e          state_q, state_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [W-1:0]    arg_q, arg_d;
  logic [W-1:0]    res_q, res_d;
  logic [OW-1:0]   grant;
  logic            any;
  logic [W-1:0]    args [N];

  fn_call_arbiter_rr_pick #(
    .N  (N),
    .OW (OW)
  ) u_pick (
    .req   (req_in_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      args[i] = req_in0[i*W +: W];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    arg_d    = arg_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          arg_d    = args[grant];
          owner_d  = grant;
          rr_ptr_d = (grant == OW'(N - 1)) ? '0 : grant + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (fn_in_ready) state_d = WAIT;
      end
      WAIT: begin
        if (fn_out_valid) begin
          res_d   = fn_out0;
          state_d = RETURN;
        end
      end
      RETURN: begin
        if (req_out_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      arg_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      arg_q    <= arg_d;
      res_q    <= res_d;
    end
  end

  // Outputs decode from registered state; only the IDLE accept
  // is combinational so a request completes in its first cycle.
  always_comb begin
    req_in_ready  = '0;
    req_out_valid = '0;
    if (state_q == IDLE && any) req_in_ready[grant] = 1'b1;
    if (state_q == RETURN) req_out_valid[owner_q] = 1'b1;
  end

  assign req_out0     = res_q;
  assign fn_in_valid  = (state_q == ISSUE);
  assign fn_in0       = arg_q;
  assign fn_out_ready = (state_q == WAIT);
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;

endmodule

// File: tb/tb_fn_call_arbiter.sv
// tb_fn_call_arbiter: drives N requesters plus a fibonacci
// function model and checks grants/results against a reference.
module tb_fn_call_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req_in_valid;
  logic [N-1:0]   req_in_ready;
  logic [N*W-1:0] req_in0;
  logic [N-1:0]   req_out_valid;
  logic [N-1:0]   req_out_ready;
  logic [W-1:0]   req_out0;
  logic           fn_in_valid;
  logic           fn_in_ready;
  logic [W-1:0]   fn_in0;
  logic           fn_out_valid;
  logic           fn_out_ready;
  logic [W-1:0]   fn_out0;
  logic           busy;
  logic [1:0]     owner;

  fn_call_arbiter #(.N(N), .W(W)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .req_in_valid  (req_in_valid),
    .req_in_ready  (req_in_ready),
    .req_in0       (req_in0),
    .req_out_valid (req_out_valid),
    .req_out_ready (req_out_ready),
    .req_out0      (req_out0),
    .fn_in_valid   (fn_in_valid),
    .fn_in_ready   (fn_in_ready),
    .fn_in0        (fn_in0),
    .fn_out_valid  (fn_out_valid),
    .fn_out_ready  (fn_out_ready),
    .fn_out0       (fn_out0),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] fib(input logic [W-1:0] n);
    logic [W-1:0] a, b, t;
    a = '0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Shared function model: fixed latency, resets with nrst.
  logic         fpend;
  int           fcnt;
  logic [W-1:0] farg;
  int           fn_lat = 0;
  logic         fn_spur = 1'b0;

  always @(posedge clk) begin
    if (!nrst) begin
      fpend <= 1'b0;
      fcnt  <= 0;
      farg  <= '0;
    end else if (!fpend) begin
      if (fn_in_valid && fn_in_ready) begin
        fpend <= 1'b1;
        fcnt  <= fn_lat;
        farg  <= fn_in0;
      end
    end else if (fcnt == 0) begin
      if (fn_out_ready) fpend <= 1'b0;
    end else begin
      fcnt <= fcnt - 1;
    end
  end

  assign fn_out_valid = (fpend && fcnt == 0) || fn_spur;
  assign fn_out0      = fn_spur ? 16'hDEAD : fib(farg);

  // Client state and observation logs
  logic [N-1:0] pv = '0;
  logic [W-1:0] pa [N];
  bit           rand_ordy = 0;
  bit           rand_frdy = 0;
  int           m_ptr = 0;
  int           g_q[$], gc_q[$], r_q[$], rc_q[$], gaps[$], exp_q[$];
  logic [W-1:0] ga_q[$], rv_q[$];
  int           bad_oh;
  bit           tmo;

  task automatic drive_req();
    req_in_valid = pv;
    for (int i = 0; i < N; i++) req_in0[i*W +: W] = pa[i];
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    pv = '0;
    drive_req();
    req_out_ready = '1;
    fn_in_ready = 1'b1;
    fn_spur = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    m_ptr = 0;
  endtask

  // Reference order: pending requesters ranked by distance from ptr.
  task automatic build_order(input logic [N-1:0] mask);
    exp_q.delete();
    for (int d = 0; d < N; d++) begin
      if (mask[(m_ptr + d) % N]) exp_q.push_back((m_ptr + d) % N);
    end
    if (exp_q.size() > 0) m_ptr = (exp_q[exp_q.size()-1] + 1) % N;
  endtask

  task automatic serve(input int want, input int budget,
                       input int drop_it, input int drop_idx,
                       output bit to);
    int lowrun;
    int hs;
    lowrun = 0;
    g_q.delete(); ga_q.delete(); gc_q.delete();
    r_q.delete(); rv_q.delete(); rc_q.delete();
    gaps.delete();
    bad_oh = 0;
    for (int it = 0; it < budget && r_q.size() < want; it++) begin
      if (it == drop_it) pv[drop_idx] = 1'b0;
      drive_req();
      req_out_ready = rand_ordy ? N'($urandom) : '1;
      fn_in_ready = rand_frdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!$onehot0(req_in_ready) || !$onehot0(req_out_valid)) bad_oh++;
      if ((req_in_ready & ~req_in_valid) != '0) bad_oh++;
      if (!busy) lowrun++;
      else if (lowrun > 0) begin
        gaps.push_back(lowrun);
        lowrun = 0;
      end
      hs = -1;
      for (int i = 0; i < N; i++) begin
        if (req_in_ready[i] && pv[i]) begin
          hs = i;
          g_q.push_back(i);
          ga_q.push_back(pa[i]);
          gc_q.push_back(cyc);
        end
        if (req_out_valid[i] && req_out_ready[i]) begin
          r_q.push_back(i);
          rv_q.push_back(req_out0);
          rc_q.push_back(cyc);
        end
      end
      @(posedge clk);
      #1;
      if (hs >= 0) pv[hs] = 1'b0;
    end
    drive_req();
    req_out_ready = '1;
    fn_in_ready = 1'b1;
    to = (r_q.size() < want);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    pv = '0;
    drive_req();
    req_out_ready = '1;
    fn_in_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, fn_in_valid, fn_out_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b exp 000", {busy, fn_in_valid, fn_out_ready});
    end
    n_tests++;
    if ({req_in_ready, req_out_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_vld: got %b exp 0", {req_in_ready, req_out_valid});
    end
    n_tests++;
    if ({req_out0, fn_in0, owner} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%0d exp 0", req_out0, fn_in0, owner);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    fn_lat = 0;
    pa[2] = 10;
    pv[2] = 1'b1;
    c0 = cyc;
    build_order(4'b0100);
    serve(1, 20, -1, 0, tmo);
    n_tests++;
    if (tmo || g_q.size() != 1 || r_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_done: grants %0d results %0d exp 1/1", g_q.size(), r_q.size());
    end else begin
      n_tests++;
      if (g_q[0] != 2 || gc_q[0] != c0) begin
        n_fail++;
        $display("FAIL single_grant: got %0d@%0d exp 2@%0d", g_q[0], gc_q[0], c0);
      end
      n_tests++;
      if (r_q[0] != 2 || rv_q[0] !== 16'd55) begin
        n_fail++;
        $display("FAIL single_result: got %0d:%0d exp 2:55", r_q[0], rv_q[0]);
      end
      n_tests++;
      if (rc_q[0] != c0 + 3) begin
        n_fail++;
        $display("FAIL single_latency: got %0d exp %0d", rc_q[0] - c0, 3);
      end
    end
    n_tests++;
    if (bad_oh != 0) begin
      n_fail++;
      $display("FAIL single_onehot: got %0d exp 0", bad_oh);
    end
  endtask

  task automatic test_contention();
    do_reset();
    pa[0] = 5; pa[1] = 6; pa[3] = 7;
    pv = 4'b1011;
    build_order(4'b1011);
    serve(3, 60, -1, 0, tmo);
    n_tests++;
    if (tmo || g_q.size() != 3) begin
      n_fail++;
      $display("FAIL cont_done: got %0d grants exp 3", g_q.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_tests++;
        if (g_q[j] != exp_q[j] || r_q[j] != exp_q[j] ||
            rv_q[j] !== fib(pa[exp_q[j]])) begin
          n_fail++;
          $display("FAIL cont_call%0d: got g%0d r%0d v%0d exp %0d v%0d",
                   j, g_q[j], r_q[j], rv_q[j], exp_q[j], fib(pa[exp_q[j]]));
        end
      end
      n_tests++;
      if (gc_q[1] - gc_q[0] != 4 || gc_q[2] - gc_q[1] != 4) begin
        n_fail++;
        $display("FAIL cont_spacing: got %0d,%0d exp 4,4",
                 gc_q[1] - gc_q[0], gc_q[2] - gc_q[1]);
      end
    end
    n_tests++;
    if (gaps.size() != 3 || gaps.sum() != 3) begin
      n_fail++;
      $display("FAIL cont_busy_gap: got %0d gaps sum %0d exp 3/3", gaps.size(), gaps.sum());
    end
  endtask

  task automatic test_wrap();
    pa[2] = 4;
    pv = 4'b0100;
    build_order(4'b0100);
    serve(1, 20, -1, 0, tmo);
    for (int i = 0; i < N; i++) pa[i] = W'(i + 8);
    pv = '1;
    build_order(4'b1111);
    serve(4, 80, -1, 0, tmo);
    n_tests++;
    if (tmo || g_q.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_done: got %0d grants exp 4", g_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_tests++;
        if (g_q[j] != exp_q[j] || rv_q[j] !== fib(pa[exp_q[j]])) begin
          n_fail++;
          $display("FAIL wrap_grant%0d: got %0d v%0d exp %0d v%0d",
                   j, g_q[j], rv_q[j], exp_q[j], fib(pa[exp_q[j]]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    fn_lat = 0;
    fn_in_ready = 1'b0;
    pa[1] = 7;
    pv = 4'b0010;
    drive_req();
    @(negedge clk);
    n_tests++;
    if (req_in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_accept: got %b exp 0010", req_in_ready);
    end
    @(posedge clk);
    #1;
    pv = 4'b0001;
    pa[0] = 3;
    drive_req();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (fn_in_valid !== 1'b1 || fn_in0 !== 16'd7 || req_in_ready !== '0) begin
        n_fail++;
        $display("FAIL bp_issue%0d: got v%b a%0d r%b exp v1 a7 r0000",
                 k, fn_in_valid, fn_in0, req_in_ready);
      end
      @(posedge clk);
      #1;
    end
    fn_in_ready = 1'b1;
    req_out_ready = 4'b1101;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (req_out_valid != '0) seen = 1;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_return_timeout: got none exp req_out_valid");
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_tests++;
      if (req_out_valid !== 4'b0010 || req_out0 !== 16'd13 || req_in_ready !== '0) begin
        n_fail++;
        $display("FAIL bp_ret%0d: got v%b d%0d r%b exp v0010 d13 r0000",
                 k, req_out_valid, req_out0, req_in_ready);
      end
      @(posedge clk);
      #1;
    end
    m_ptr = 2;
    build_order(4'b0001);
    serve(2, 40, -1, 0, tmo);
    n_tests++;
    if (tmo || r_q.size() != 2 || r_q[0] != 1 || r_q[1] != exp_q[0] ||
        rv_q[0] !== 16'd13 || rv_q[1] !== fib(16'd3)) begin
      n_fail++;
      $display("FAIL bp_results: got %0d results exp owners 1,0 values 13,2", r_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    fn_lat = 3;
    pa[2] = 9;
    pv = 4'b0100;
    drive_req();
    @(negedge clk);
    @(posedge clk);
    #1;
    pv = '0;
    drive_req();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (fn_out_ready) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_wait_timeout: got no WAIT exp fn_out_ready");
    end
    @(posedge clk);
    #1 nrst = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    m_ptr = 0;
    n_tests++;
    if ({busy, fn_in_valid, fn_out_ready, req_in_ready, req_out_valid} !== '0 ||
        {req_out0, fn_in0, owner} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got b%b v%b d%h owner %0d exp all 0",
               busy, req_out_valid, req_out0, owner);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_out_valid != '0 || busy) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_no_result: got activity exp idle");
    end
    @(posedge clk);
    #1;
    fn_lat = 1;
    pa[0] = 10;
    pa[3] = 10;
    pv = 4'b1001;
    build_order(4'b1001);
    serve(2, 40, -1, 0, tmo);
    n_tests++;
    if (tmo || g_q.size() != 2 || g_q[0] != 0 || g_q[1] != 3 ||
        rv_q[0] !== 16'd55 || rv_q[1] !== 16'd55) begin
      n_fail++;
      $display("FAIL mid_fresh: got %0d calls exp grants 0,3 values 55", g_q.size());
    end
  endtask

  task automatic test_spurious_withdraw();
    do_reset();
    fn_lat = 0;
    fn_spur = 1'b1;
    @(negedge clk);
    n_tests++;
    if (fn_out_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_ready: got r%b b%b exp 0 0", fn_out_ready, busy);
    end
    @(posedge clk);
    #1 fn_spur = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || req_out_valid !== '0) begin
      n_fail++;
      $display("FAIL spur_ignored: got b%b v%b exp 0 0000", busy, req_out_valid);
    end
    @(posedge clk);
    #1;
    pa[0] = 4; pa[1] = 5; pa[2] = 6;
    pv = 4'b0111;
    serve(2, 40, 2, 1, tmo);
    n_tests++;
    if (tmo || g_q.size() != 2 || g_q[0] != 0 || g_q[1] != 2 ||
        rv_q[0] !== fib(16'd4) || rv_q[1] !== fib(16'd6)) begin
      n_fail++;
      $display("FAIL withdraw: got %0d grants exp 0,2 values 3,8", g_q.size());
    end
    m_ptr = 3;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    rand_ordy = 1;
    rand_frdy = 1;
    for (int rnd = 0; rnd < 20; rnd++) begin
      fn_lat = $urandom_range(0, 3);
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) pa[i] = W'($urandom_range(0, 24));
      pv = mask;
      build_order(mask);
      serve(exp_q.size(), 400, -1, 0, tmo);
      n_tests++;
      if (tmo || g_q.size() != exp_q.size() || bad_oh != 0) begin
        n_fail++;
        $display("FAIL rand%0d_done: got %0d grants oh%0d exp %0d",
                 rnd, g_q.size(), bad_oh, exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          n_tests++;
          if (g_q[j] != exp_q[j] || ga_q[j] !== pa[exp_q[j]] ||
              r_q[j] != exp_q[j] || rv_q[j] !== fib(pa[exp_q[j]])) begin
            n_fail++;
            $display("FAIL rand%0d_call%0d: got g%0d r%0d v%0d exp %0d v%0d",
                     rnd, j, g_q[j], r_q[j], rv_q[j], exp_q[j], fib(pa[exp_q[j]]));
          end
        end
      end
    end
    rand_ordy = 0;
    rand_frdy = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) pa[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_spurious_withdraw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fn_call_arbiter.md
Name: fn_call_arbiter

Overview:
- Shares one generated function instance (e.g. tests_fib) between N requesters over the standard sync handshake (in_valid/in_ready, out_valid/out_ready).
- Each requester presents an argument; the arbiter grants round-robin and issues one call at a time to the shared function.
- The result is returned only to the requester that issued the call.
- Sits between client logic and the single function instance, which takes the same clk/nrst.

Parameters:
- N, 4, number of requesters (1..16)
- W, `intN (16), argument/result width in bits

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- req_in_valid  in  N  per-requester call request
- req_in_ready  out  N  per-requester accept, one-hot or zero
- req_in0  in  N*W  packed args; requester i at [i*W +: W]
- req_out_valid  out  N  per-requester result valid, one-hot or zero
- req_out_ready  in  N  per-requester result accept
- req_out0  out  W  result, shared by all requesters; qualified by req_out_valid
- fn_in_valid  out  1  call to shared function
- fn_in_ready  in  1  function accepts call
- fn_in0  out  W  argument to function
- fn_out_valid  in  1  function result valid
- fn_out_ready  out  1  arbiter accepts result
- fn_out0  in  W  function result
- busy  out  1  high in any state except IDLE
- owner  out  clog2(N) (min 1)  index of current grant; debug only

Behaviour:
- Reset is synchronous, active-low, and taken on any clk edge with nrst=0:
  - state=IDLE, rr_ptr=0, owner=0, arg_r=0, res_r=0.
  - All valid/ready outputs 0; req_out0=0; busy=0.
- Reset mid-call abandons the call silently; no result is delivered afterwards. The shared function shares nrst.
- States IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
- IDLE:
  - Grant g = first i with req_in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N.
  - If any request: req_in_ready[g]=1 combinationally this cycle, so the handshake completes this edge.
  - On that edge: arg_r<=req_in0[g], owner<=g, rr_ptr<=(g+1) mod N, state<=ISSUE.
  - If no request: hold; all ready outputs 0.
- ISSUE:
  - fn_in_valid=1 and fn_in0=arg_r, held until fn_in_ready=1, then state<=WAIT.
  - fn_in_valid is registered/state-decoded and never combinational from req_*.
- WAIT:
  - fn_out_ready=1.
  - On fn_out_valid: res_r<=fn_out0, state<=RETURN.
  - fn_out_valid seen in any other state is ignored, and fn_out_ready=0 outside WAIT.
- RETURN:
  - req_out_valid[owner]=1 and req_out0=res_r, held until req_out_ready[owner]=1, then state<=IDLE.
  - Ready inputs of other requesters are ignored.
- Only one call is outstanding at a time. req_in_ready is all zero outside IDLE.
- Requesters may drop req_in_valid before being granted; nothing is latched for them.
- Minimum occupancy with a zero-latency function:
  - accept edge at cycle 0;
  - fn_in_valid in cycle 1;
  - fn_out_valid in cycle 2 at the earliest;
  - req_out_valid in cycle 3;
  - back in IDLE at cycle 4.
  - The next grant may occur in cycle 4.
- Fairness: with all N requesting continuously, grants go 0,1,...,N-1,0,...
- The pointer update wraps via explicit compare, not power-of-two masking, so N=3 etc. are legal.
- N=1 degenerates to a pass-through sequencer with the same latency.
- Data is W bits unmodified end to end; no truncation or extension.

Decomposition:
- Shared include (alongside primitives.v) holds:
  - state encodings IDLE=0, ISSUE=1, WAIT=2, RETURN=3 (2 bits);
  - the `intT/`intN width macros.
- One natural sub-module: rr_pick, combinational. Inputs N-bit request vector and rr_ptr; outputs grant index and any.
- FSM, registers and output muxing stay in fn_call_arbiter.

Test Plan:
- Single call, N=4 W=16, wired to tests_fib:
  - requester 2 sends 10 for one cycle; all out_ready=1.
  - req_in_ready[2] pulses in the same cycle.
  - Later req_out_valid=4'b0100 with req_out0=55; no other valid bit is ever set.
- Contention: requesters 0,1,3 assert simultaneously with args 5,6,7 and hold until accepted.
  - Grant order is 0,1,3.
  - Results 5,8,13 arrive on out_valid bits 0,1,3 respectively.
  - busy is low for exactly one cycle between calls.
- Round-robin wrap: rr_ptr at 3 after granting 2; all four request.
  - Grant order is 3,0,1,2.
- Backpressure:
  - hold fn_in_ready=0 for 5 cycles: fn_in_valid and fn_in0 stay stable.
  - hold req_out_ready[owner]=0 for 7 cycles: req_out_valid and req_out0 stay stable.
  - A new request during either stall sees req_in_ready=0.
- Reset mid-call: nrst=0 for 1 cycle while in WAIT.
  - All outputs are 0 the next cycle; state is IDLE; rr_ptr=0.
  - No req_out_valid appears.
  - A fresh call with arg 10 then returns 55.
- Spurious/withdrawn: fn_out_valid pulsed in IDLE is ignored. A requester that drops valid before its grant is skipped, and the grant goes to the next valid index.
